// File: rtl/hack_ctrl_pkg.sv
// rtl/hack_ctrl_pkg.sv - shared types and constants for the Hack boot/run controller
package hack_ctrl_pkg;

    localparam int HACK_WORD_W = 16;
    localparam int HACK_ROM_AW = 15;

    // The low three bits of this encoding are exported as state_o.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_HDR_HI = 4'd1,
        ST_HDR_LO = 4'd2,
        ST_DAT_HI = 4'd3,
        ST_DAT_LO = 4'd4,
        ST_BOOT   = 4'd5,
        ST_RUN    = 4'd6,
        ST_HALT   = 4'd7,
        ST_STEP   = 4'd8
    } ctrl_state_e;

    function automatic logic is_load_state(input ctrl_state_e s);
        return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DAT_HI) || (s == ST_DAT_LO);
    endfunction

endpackage

// File: rtl/hack_word_assembler.sv
// rtl/hack_word_assembler.sv - pairs big-endian hi/lo bytes into one 16-bit word
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   byte_in        incoming loader byte
//   hi_en          byte_in is a high byte being accepted this cycle
//   lo_en          byte_in is a low byte being accepted this cycle
//   word           {held high byte, byte_in}; meaningful while word_valid=1
//   word_valid     one-cycle pulse on the cycle the low byte is accepted
module hack_word_assembler
    import hack_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             byte_in,
    input  logic                   hi_en,
    input  logic                   lo_en,
    output logic [HACK_WORD_W-1:0] word,
    output logic                   word_valid
);

    logic [7:0] hi_q;
    logic [7:0] hi_d;

    always_comb begin
        hi_d = hi_q;
        if (hi_en) begin
            hi_d = byte_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
        end else begin
            hi_q <= hi_d;
        end
    end

    // The word is presented combinationally with the low byte so the
    // controller can latch the header count or issue the ROM write at once.
    assign word       = {hi_q, byte_in};
    assign word_valid = lo_en;

endmodule

// File: rtl/hack_run_ctrl.sv
// rtl/hack_run_ctrl.sv - Hack CPU boot loader and run/halt/step clock-enable controller
// Ports:
//   clk, reset                     clock, asynchronous active-high reset (-> IDLE)
//   load_start                     pulse: begin a program load (IDLE/RUN/HALT/STEP)
//   byte_in/byte_valid/byte_ready  loader byte stream, accepted on valid && ready
//   run_req/halt_req/step_req      run-control pulses
//   pc, brk_addr                   breakpoint compare inputs
//   rom_we/rom_addr/rom_wdata      instruction ROM write port
//   cpu_reset, cpu_ce              CPU reset and clock enable
//   load_err                       sticky: header word count larger than the ROM
//   state_o                        low three bits of the FSM state
// Build option: define HACK_BREAKPOINT_EN to halt in RUN when pc == brk_addr.
module hack_run_ctrl
    import hack_ctrl_pkg::*;
#(
    parameter int ROM_AW = HACK_ROM_AW,
    parameter int WORD_W = HACK_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [ROM_AW-1:0] pc,
    input  logic [ROM_AW-1:0] brk_addr,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_wdata,
    output logic              cpu_reset,
    output logic              cpu_ce,
    output logic              load_err,
    output logic [2:0]        state_o
);

    localparam logic [16:0] ROM_WORDS = 17'd1 << ROM_AW;

    ctrl_state_e       state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [ROM_AW-1:0] cnt_q, cnt_d;
    logic              byte_ready_q, byte_ready_d;
    logic              rom_we_q, rom_we_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [WORD_W-1:0] rom_wdata_q, rom_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              cpu_ce_q, cpu_ce_d;
    logic              load_err_q, load_err_d;

    logic              accept;
    logic [15:0]       word;
    logic              word_valid;
    logic              last_word;
    logic              brk_hit;

    assign accept = byte_valid && byte_ready_q;

    hack_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .hi_en      (accept && (state_q == ST_HDR_HI || state_q == ST_DAT_HI)),
        .lo_en      (accept && (state_q == ST_HDR_LO || state_q == ST_DAT_LO)),
        .word       (word),
        .word_valid (word_valid)
    );

    // Counter stops at N-1 instead of incrementing, so a full-size load
    // finishes at the top address without wrapping to 0.
    assign last_word = (17'(cnt_q) == (17'(n_q) - 17'd1));

`ifdef HACK_BREAKPOINT_EN
    assign brk_hit = (state_q == ST_RUN) && (pc == brk_addr);
`else
    logic unused_brk;
    assign unused_brk = ^{pc, brk_addr};
    assign brk_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        load_err_d  = load_err_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;

        case (state_q)
            ST_IDLE: ;
            ST_HDR_HI: if (accept) state_d = ST_HDR_LO;
            ST_HDR_LO: begin
                if (word_valid) begin
                    n_d   = word;
                    cnt_d = '0;
                    if (word == 16'd0) begin
                        state_d = ST_BOOT;
                    end else if ({1'b0, word} > ROM_WORDS) begin
                        state_d    = ST_IDLE;
                        load_err_d = 1'b1;
                    end else begin
                        state_d = ST_DAT_HI;
                    end
                end
            end
            ST_DAT_HI: if (accept) state_d = ST_DAT_LO;
            ST_DAT_LO: begin
                if (word_valid) begin
                    rom_we_d    = 1'b1;
                    rom_addr_d  = cnt_q;
                    rom_wdata_d = WORD_W'(word);
                    if (last_word) begin
                        state_d = ST_BOOT;
                    end else begin
                        cnt_d   = cnt_q + ROM_AW'(1);
                        state_d = ST_DAT_HI;
                    end
                end
            end
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt_req || brk_hit) state_d = ST_HALT;
            ST_HALT: begin
                if (halt_req)     state_d = ST_HALT;
                else if (step_req) state_d = ST_STEP;
                else if (run_req)  state_d = ST_RUN;
            end
            ST_STEP: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        // A new load overrides run control in every non-load state except BOOT.
        if (load_start && (state_q == ST_IDLE || state_q == ST_RUN ||
                           state_q == ST_HALT || state_q == ST_STEP)) begin
            state_d    = ST_HDR_HI;
            load_err_d = 1'b0;
        end

        // Registered outputs are derived from the next state so they line up
        // with the state they describe.
        byte_ready_d = is_load_state(state_d);
        cpu_reset_d  = !(state_d == ST_RUN || state_d == ST_HALT || state_d == ST_STEP);
        cpu_ce_d     = (state_d == ST_BOOT) || (state_d == ST_RUN) || (state_d == ST_STEP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            cnt_q        <= '0;
            byte_ready_q <= 1'b0;
            rom_we_q     <= 1'b0;
            rom_addr_q   <= '0;
            rom_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            cpu_ce_q     <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            byte_ready_q <= byte_ready_d;
            rom_we_q     <= rom_we_d;
            rom_addr_q   <= rom_addr_d;
            rom_wdata_q  <= rom_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            cpu_ce_q     <= cpu_ce_d;
            load_err_q   <= load_err_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_wdata  = rom_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    // A breakpoint hit must stop the instruction at pc in this very cycle.
    assign cpu_ce     = cpu_ce_q & ~brk_hit;
    assign load_err   = load_err_q;
    assign state_o    = state_q[2:0];

endmodule
